// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
// Sends one byte as a two-wire serial frame on sda/sck. The frame is a start
// marker (1), eight data bits MSB first, an optional even-parity bit and a stop
// marker (0). sck is derived from clk with a phase counter, so the whole block
// lives in the clk domain.
//
// Optional feature macro: SERIAL_TX_PARITY_EN
//   defined   -> even-parity bit inserted between the LSB and the stop marker
//   undefined -> no parity state or parity logic at all
//
// Parameters
//   CLK_DIV : sck half-period in clk cycles (>= 1); one bit lasts 2*CLK_DIV
// Ports
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   start in  frame request, accepted only when idle or in the DONE cycle
//   data  in  byte to send, latched on acceptance
//   busy  out high while a frame is on the wire
//   done  out one-cycle pulse right after a frame completes
//   sda   out serial data, changes only at phase 0 while sck is low
//   sck   out serial clock, rises mid-bit
// -----------------------------------------------------------------------------
module serial_frame_tx #(
  parameter int unsigned CLK_DIV = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       sda,
  output logic       sck
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PH_W   = (CLK_DIV == 0) ? 1 : $clog2(2 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_MAX  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV);

  // Reject a zero divider at elaboration time.
  if (CLK_DIV == 0) begin : g_clk_div_check
    $error("serial_frame_tx: CLK_DIV must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PH_W-1:0]     r_phase;
  logic [PH_W-1:0]     w_phase_nxt;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [CNT_W-1:0]    w_bit_cnt_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
`ifdef SERIAL_TX_PARITY_EN
  logic                r_parity;
  logic                w_parity_nxt;
`endif
  logic                r_busy;
  logic                r_done;
  logic                r_sda;
  logic                r_sck;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_sda_nxt;
  logic                w_sck_nxt;
  logic                w_bit_end;

  assign w_bit_end = (r_phase == PH_MAX);

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sda     <= 1'b0;
      r_sck     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_sda     <= w_sda_nxt;
      r_sck     <= w_sck_nxt;
    end
  end

  // Next-state logic; outputs are decoded from the next state so that they
  // land in their registers on the same edge as the state they describe.
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = w_bit_end ? '0 : r_phase + PH_W'(1);
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
`ifdef SERIAL_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_sda_nxt     = 1'b0;
    w_sck_nxt     = 1'b0;

    case (r_state)
      // DONE behaves like IDLE for acceptance, giving back-to-back frames.
      S_IDLE, S_DONE: begin
        w_phase_nxt = '0;
        if (start) begin
          w_state_nxt   = S_START;
          w_shift_nxt   = data;
          w_bit_cnt_nxt = CNT_W'(DATA_W - 1);
`ifdef SERIAL_TX_PARITY_EN
          w_parity_nxt  = ^data;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == '0) begin
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
            w_shift_nxt   = {r_shift[DATA_W-2:0], 1'b0};
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
      end
    endcase

    // Output decode from the upcoming state.
    case (w_state_nxt)
      S_START: begin
        w_busy_nxt = 1'b1;
        w_sda_nxt  = 1'b1;
      end
      S_DATA: begin
        w_busy_nxt = 1'b1;
        w_sda_nxt  = w_shift_nxt[DATA_W-1];
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        w_busy_nxt = 1'b1;
        w_sda_nxt  = w_parity_nxt;
      end
`endif
      S_STOP: begin
        w_busy_nxt = 1'b1;
        w_sda_nxt  = 1'b0;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase

    // sck is low for the first half of each bit and high for the second.
    w_sck_nxt = w_busy_nxt && (w_phase_nxt >= PH_HIGH);
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sda  = r_sda;
  assign sck  = r_sck;

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
// Directed bench for serial_frame_tx. Two instances (CLK_DIV=2 and CLK_DIV=1)
// share the stimulus; sel chooses which one is observed. Expected frames are
// queued when a frame is requested and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       sel;

  logic busy1, done1, sda1, sck1;
  logic busy2, done2, sda2, sck2;
  logic m_busy, m_done, m_sda, m_sck;

  always #5 clk = ~clk;

  serial_frame_tx #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .busy(busy2), .done(done2), .sda(sda2), .sck(sck2)
  );

  serial_frame_tx #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .busy(busy1), .done(done1), .sda(sda1), .sck(sck1)
  );

  assign m_busy = sel ? busy1 : busy2;
  assign m_done = sel ? done1 : done2;
  assign m_sda  = sel ? sda1  : sda2;
  assign m_sck  = sel ? sck1  : sck2;

  typedef struct {
    logic [10:0] bits;
    int          n;
    int          blen;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          n_done    = 0;
  int          n_pushed  = 0;
  int          both_err  = 0;
  logic [10:0] cap       = '0;
  int          cap_n     = 0;
  int          blen      = 0;
  logic        prev_sck  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference frame: start marker, byte MSB first, optional parity, stop.
  function automatic exp_t make_exp(input logic [7:0] d, input int div);
    exp_t e;
`ifdef SERIAL_TX_PARITY_EN
    e.n    = 11;
    e.bits = {1'b1, d, ^d, 1'b0};
`else
    e.n    = 10;
    e.bits = {1'b0, 1'b1, d, 1'b0};
`endif
    e.blen = e.n * 2 * div;
    return e;
  endfunction

  task automatic push_exp(input logic [7:0] d);
    exp_q.push_back(make_exp(d, sel ? 1 : 2));
    n_pushed++;
  endtask

  // Per-cycle observation of the selected DUT, run at each falling edge.
  task automatic sample();
    exp_t e;
    if (rst) begin
      cap      = '0;
      cap_n    = 0;
      blen     = 0;
      prev_sck = 1'b0;
      return;
    end
    if (m_busy && m_done) both_err++;
    if (m_busy) blen++;
    if (m_sck && !prev_sck) begin
      cap   = {cap[9:0], m_sda};
      cap_n++;
    end
    prev_sck = m_sck;
    if (m_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", n_done, n_pushed);
      end else begin
        e = exp_q.pop_front();
        chk("frame_sck_edges", cap_n, e.n);
        chk("frame_bits", 32'(cap), 32'(e.bits));
        chk("frame_busy_len", blen, e.blen);
      end
      cap   = '0;
      cap_n = 0;
      blen  = 0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!m_done && k < budget);
    chk("done_in_time", m_done, 1'b1);
  endtask

  // One-cycle start pulse with the matching expectation queued.
  task automatic send(input logic [7:0] d);
    data  = d;
    start = 1'b1;
    push_exp(d);
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    data  = 8'h00;
    sel   = 1'b0;

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    chk("rst_sda",  m_sda,  1'b0);
    chk("rst_sck",  m_sck,  1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_done", m_done, 1'b0);
    cycles(3);
    chk("rst_hold", {m_sda, m_sck, m_busy, m_done}, 4'b0000);
    rst = 1'b0;
    cycles(2);

    // Single frame 0xA5 at CLK_DIV=2.
    send(8'hA5);
    chk("accept_busy", m_busy, 1'b1);
    chk("start_marker", m_sda, 1'b1);
    chk("start_sck_low", m_sck, 1'b0);
    data = 8'h3C;
    wait_done(200);
    chk("done_busy_low", m_busy, 1'b0);
    cyc();
    chk("done_one_cycle", m_done, 1'b0);
    chk("idle_sda", m_sda, 1'b0);
    cycles(3);

    // start while busy is ignored.
    send(8'h00);
    cycles(10);
    data  = 8'hFF;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(200);
    cycles(60);
    chk("no_second_frame", m_busy, 1'b0);
    chk("ignored_done_count", n_done, n_pushed);

    // Reset in the middle of data bit 3 (frame bit 4, sck high).
    data  = 8'hFF;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cycles(18);
    chk("pre_abort_busy", m_busy, 1'b1);
    chk("pre_abort_sck", m_sck, 1'b1);
    chk("pre_abort_sda", m_sda, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", {m_sda, m_sck, m_busy, m_done}, 4'b0000);
    cycles(2);
    chk("abort_hold", {m_sda, m_sck, m_busy, m_done}, 4'b0000);
    rst = 1'b0;
    cycles(60);
    chk("abort_no_done", n_done, n_pushed);
    send(8'h3C);
    wait_done(200);
    cycles(2);

    // start held high: back-to-back frames with a single DONE gap.
    data  = 8'h5A;
    start = 1'b1;
    push_exp(8'h5A);
    cyc();
    data = 8'hC3;
    push_exp(8'hC3);
    wait_done(200);
    chk("gap_busy_low", m_busy, 1'b0);
    cyc();
    start = 1'b0;
    chk("gap_next_busy", m_busy, 1'b1);
    chk("gap_next_sda", m_sda, 1'b1);
    wait_done(200);
    cycles(60);
    chk("held_stop_busy", m_busy, 1'b0);
    chk("held_done_count", n_done, n_pushed);

    // CLK_DIV=1 instance: parity frames.
    rst = 1'b1;
    cycles(2);
    sel = 1'b1;
    rst = 1'b0;
    cycles(2);
    send(8'h07);
    wait_done(100);
    cycles(2);
    send(8'hA5);
    wait_done(100);
    cycles(5);

    chk("done_busy_exclusive", both_err, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("total_done_count", n_done, n_pushed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that converts a parallel byte into a clocked two-wire stream on `sda`/`sck`. It sits downstream of the breadboard-button control logic: a one-cycle `start` request launches one frame for a logic analyser or a downstream serial receiver to capture. The serial clock is generated internally with a clock-enable counter, so the whole block runs in the `clk` domain. Each frame is a start marker, 8 data bits MSB first, an optional even-parity bit, and a stop marker.

## Interface
- `CLK_DIV`, default 12: `sck` half-period in `clk` cycles. Must be at least 1; 0 is an elaboration error.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: frame request, sampled on `clk` rising edges.
- `data`, input, 8: byte to send, latched when the frame is accepted.
- `busy`, output, 1: high while a frame is in progress.
- `done`, output, 1: one-cycle pulse after a frame completes.
- `sda`, output, 1: serial data.
- `sck`, output, 1: serial clock.

## Operation
- **Reset values:** `sda`=0, `sck`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- **States:** IDLE → START → DATA → PARITY (compiled in only) → STOP → DONE → IDLE.
- **IDLE and DONE:** if `start`=1 at a rising edge, latch `data` into an 8-bit shift register, load the bit counter with 7, go to START.
- **START:** `sda`=1 for one bit period.
- **DATA:** `sda` = shift-register MSB, shifted left at each bit boundary. Leave after the bit with counter 0 completes.
- **PARITY:** `sda` = XOR of the latched byte (even parity), one bit period.
- **STOP:** `sda`=0 for one bit period.
- **DONE:** lasts exactly one cycle with `done`=1 and `busy`=0, then returns to IDLE unless a new `start` is accepted.
- **Bit period:** 2×`CLK_DIV` cycles.
  - Phase counter runs 0..2×`CLK_DIV`−1 and wraps to 0 at each bit boundary.
  - `sck`=0 for phase < `CLK_DIV` and 1 otherwise, so the rising edge of `sck` is mid-bit.
  - `sda` changes only at phase 0, while `sck` is low.
- **Outside a frame:** `sck`=0 and `sda`=0.
- **`start` while busy:** ignored, not queued.
- **`data` changes after acceptance:** no effect on the frame in progress.
- **`rst` mid-frame:** all outputs return immediately to reset values. The aborted frame produces no `done` pulse.
- **`start` held high:** frames run back-to-back, separated only by the single DONE cycle.

## Timing
- **Acceptance:** on the accepting edge T, from T+1 `busy`=1 and `sda` carries the start marker. This is phase 0 of bit 0.
- **Frame length:** N = 10 bits (11 with parity).
  - `busy` is high for exactly N×2×`CLK_DIV` cycles.
  - `done`=1 in the first cycle with `busy`=0; `done` and `busy` are never both high.
- **`sck` timing:** bit k's `sck` rising edge falls at T+1+k×2×`CLK_DIV`+`CLK_DIV`. `sck` makes exactly N rising edges per frame.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- **Macro:** `SERIAL_TX_PARITY_EN`.
- **Defined:** the PARITY state is compiled in and N=11; the parity bit is sent after the LSB and before STOP.
- **Undefined:** no PARITY state or XOR logic exists, N=10, and STOP follows the LSB directly.

## Test plan
- **Reset:** assert `rst` asynchronously between clock edges. `sda`, `sck`, `busy` and `done` are all 0 at once and stay 0 while `rst`=1.
- **Single frame:** `CLK_DIV`=2, parity off, `data`=0xA5, one-cycle `start`.
  - `sda` sampled at the `sck` rising edges reads 1,1,0,1,0,0,1,0,1,0.
  - `busy` is high for 40 cycles, then `done` pulses once.
- **Parity:** parity on, `CLK_DIV`=1.
  - `data`=0x07: 11 `sck` rising edges, parity bit=1, `busy` high for 22 cycles.
  - `data`=0xA5: parity bit=0.
- **Ignored `start`:** pulse `start` with `data`=0xFF mid-frame of a 0x00 frame. That frame's data bits are all 0, no second frame follows, and exactly one `done` pulse occurs.
- **Reset mid-frame:** assert `rst` during DATA bit 3. Outputs go to 0 immediately and no `done` pulse occurs. After release, a 0x3C frame transmits correctly.
- **Held `start`:** `CLK_DIV`=2, parity off.
  - Consecutive frames are separated by exactly one cycle with `busy`=0 and `done`=1.
  - The second frame carries the `data` value present on the DONE-cycle edge.
